// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per enabled cycle out.
// Optional SERIALIZER_PARITY_EN appends an even-parity bit after each word.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(NBITS - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("bit_serializer: WIDTH must be >= 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             obit_q, obit_d;
    logic             ovalid_q, ovalid_d;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             xfer;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] sh_next;
    logic             data_bit;
    logic             emit;

    assign in_ready  = !hold_full_q;
    assign xfer      = in_valid && in_ready;
    assign out_bit   = obit_q;
    assign out_valid = ovalid_q;
    assign busy      = (state_q == SHIFT) || hold_full_q;

    assign data_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign sh_next  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};

`ifdef SERIALIZER_PARITY_EN
    // Last counted slot of a word carries the parity bit, not data
    assign emit = (cnt_q == '0) ? par_q : data_bit;
`else
    assign emit = data_bit;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        obit_d      = 1'b0;
        ovalid_d    = 1'b0;
        load        = 1'b0;
        load_val    = in_data;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    obit_d   = emit;
                    ovalid_d = 1'b1;
                    shreg_d  = sh_next;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                        if (xfer) begin
                            hold_d      = in_data;
                            hold_full_d = 1'b1;
                        end
                    end else if (hold_full_q) begin
                        load        = 1'b1;
                        load_val    = hold_q;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    hold_d      = in_data;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shreg_d = load_val;
            cnt_d   = CNT_LOAD;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    always_comb begin
        par_d = par_q;
        if (load) begin
            par_d = ^load_val;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            obit_q      <= 1'b0;
            ovalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            obit_q      <= obit_d;
            ovalid_q    <= ovalid_d;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances share stimulus.
// Expected bit streams are built from each accepted word; a monitor pops and compares.
module tb_bit_serializer;
    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         en = 1'b1;
    logic         in_ready0, ob0, ov0, busy0;
    logic         in_ready1, ob1, ov1, busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int en_mode  = 0;
    bit q0[$];
    bit q1[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .en(en), .out_bit(ob0), .out_valid(ov0),
        .busy(busy0)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .en(en), .out_bit(ob1), .out_valid(ov1),
        .busy(busy1)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference stream for one word: data bits in emit order, then parity if enabled
    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            q0.push_back(w[W-1-i]);
            q1.push_back(w[i]);
        end
`ifdef SERIALIZER_PARITY_EN
        q0.push_back(^w);
        q1.push_back(^w);
`endif
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_word(input logic [W-1:0] w);
        int waits = 0;
        in_data  = w;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready0) break;
            waits++;
            if (waits > 500) begin
                check_int("send_timeout", waits, 0);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        push_word(w);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for both streams to empty, then expect a fully idle block
    task automatic wait_drain(input string name);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_int({name, "_drained"}, q0.size() + q1.size(), 0);
        @(negedge clk);
        @(negedge clk);
        check_bit({name, "_ov_idle"}, ov0, 1'b0);
        check_bit({name, "_busy0_idle"}, busy0, 1'b0);
        check_bit({name, "_busy1_idle"}, busy1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid bit must match the head of its stream; gaps must be zero
    always @(negedge clk) begin
        if (rst) begin
            if (ov0) begin
                if (q0.size() == 0) check_int("sb0_underflow", 1, 0);
                else check_bit("sb0_bit", ob0, q0.pop_front());
            end else begin
                check_bit("gap0_zero", ob0, 1'b0);
            end
            if (ov1) begin
                if (q1.size() == 0) check_int("sb1_underflow", 1, 0);
                else check_bit("sb1_bit", ob1, q1.pop_front());
            end else begin
                check_bit("gap1_zero", ob1, 1'b0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (en_mode == 0) en = 1'b1;
            else if (en_mode == 1) en = !en;
            else en = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        int seen;
        int k;

        #3;
        check_bit("rst_ov", ov0, 1'b0);
        check_bit("rst_ob", ob0, 1'b0);
        check_bit("rst_busy", busy0, 1'b0);
        check_bit("rst_ready", in_ready0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_bit("post_rst_ready", in_ready0, 1'b1);
        check_bit("post_rst_ov", ov1, 1'b0);
        @(posedge clk);
        #1;

        // Single word, latency of one enabled cycle
        send_word(8'hA5);
        @(negedge clk);
        check_bit("lat_wait", ov0, 1'b0);
        @(negedge clk);
        check_bit("lat_first", ov0, 1'b1);
        @(posedge clk);
        #1;
        wait_drain("single");

        // Three words back to back: one unbroken run of valid bits
        run = 0;
        fork
            begin
                send_word(8'hA5);
                send_word(8'h3C);
                check_bit("hold_full_ready", in_ready0, 1'b0);
                check_bit("hold_full_busy", busy0, 1'b1);
                send_word(8'h5A);
            end
            begin
                k = 0;
                while (!ov0 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                while (ov0 && run < 100) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        check_int("stream_run", run, 3 * NB);
        @(posedge clk);
        #1;
        wait_drain("stream");

        // Half-rate enable: busy held until the last bit appears
        en_mode = 1;
        send_word(8'hF0);
        seen = 0;
        k = 0;
        while (seen < NB && k < 200) begin
            @(negedge clk);
            k++;
            if (ov0) seen++;
            if (seen < NB) check_bit("alt_busy", busy0, 1'b1);
        end
        check_int("alt_bits", seen, NB);
        en_mode = 0;
        @(posedge clk);
        #1;
        wait_drain("alt");

        // Bit-order distinguishing word
        send_word(8'h01);
        wait_drain("lsb");

        // Asynchronous reset in the middle of a word
        send_word(8'hFF);
        seen = 0;
        k = 0;
        while (seen < 3 && k < 100) begin
            @(negedge clk);
            k++;
            if (ov0) seen++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_bit("arst_ov", ov0, 1'b0);
        check_bit("arst_ob", ob0, 1'b0);
        check_bit("arst_busy", busy0, 1'b0);
        check_bit("arst_ready", in_ready0, 1'b1);
        check_bit("arst_busy1", busy1, 1'b0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_word(8'h80);
        wait_drain("after_rst");

        // Contiguous pair whose parities differ
        send_word(8'h07);
        send_word(8'h03);
        wait_drain("pair");

        // Random words, random gaps, random enable
        en_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send_word(W'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 4));
        end
        en_mode = 0;
        @(posedge clk);
        #1;
        wait_drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial sequence detectors in this codebase (e.g. the 101 detector).
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per enabled cycle on out_bit, which drives the detector's x input, qualified by out_valid.
- Holds one word in a buffer behind the shift register, so back-to-back words stream with no bubble.

Parameters:
- WIDTH, 8: word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1: 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- en  input  1  bit-rate enable; a bit is emitted only in cycles with en=1.
- out_bit  output  1  serial data; feeds the detector's x.
- out_valid  output  1  out_bit carries a real data bit.
- busy  output  1  shift register or holding buffer occupied.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hold buffer empty, shift reg=0, bit counter=0, out_bit=0, out_valid=0, busy=0.
- in_ready is combinational: in_ready = !hold_full. It is 1 during and right after reset.
- Handshake: a word transfers on a rising edge where in_valid && in_ready. in_data is sampled only on that edge.
- Counter width is $clog2(WIDTH); it counts the bits remaining after the current one.
- State IDLE:
  - On transfer: shift reg <= in_data, cnt <= WIDTH-1, go to SHIFT. The hold buffer stays empty.
  - out_valid=0, out_bit=0.
- State SHIFT, edge with en=1:
  - out_bit <= current bit (shreg[WIDTH-1] if MSB_FIRST, else shreg[0]); out_valid <= 1.
  - Shift by one toward the emit end.
  - If cnt != 0: cnt <= cnt-1. A transfer this edge goes into the hold buffer.
  - If cnt == 0 (last bit) and hold is full: load shreg from hold, mark hold empty, cnt <= WIDTH-1, stay in SHIFT. A transfer on the same edge refills hold (in_ready was 0, so none occurs).
  - If cnt == 0 and hold is empty with a transfer on this edge: load shreg directly from in_data (bypass), stay in SHIFT.
  - If cnt == 0, hold empty, no transfer: go to IDLE.
- State SHIFT, edge with en=0:
  - out_valid <= 0, out_bit <= 0.
  - No shift, cnt unchanged. A transfer still fills the hold buffer.
- out_bit is forced to 0 whenever out_valid=0, so an ungated detector only ever sees zeros in idle gaps.
- Latency: word accepted at edge E in IDLE; first bit visible after the first edge after E with en=1. With en held at 1, that is one cycle.
- Throughput: with en=1 and words always available, out_valid stays 1 continuously; exactly WIDTH bits per word, no gaps.
- busy = (state==SHIFT) || hold_full, registered-equivalent (derived from registers only).
- Reset mid-word: any partially shifted word and any held word are discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After the last data bit of each word, one extra bit is emitted: the even-parity bit (XOR of all WIDTH data bits, captured at load).
  - Each word occupies WIDTH+1 enabled cycles. Hold reload and bypass happen after the parity bit.
  - The counter is widened to $clog2(WIDTH+1).
- Undefined: no parity bit, WIDTH bits per word, no parity register.

Test Plan:
- Reset, en=1, MSB_FIRST=1, send 8'hA5 once -> out_bit 1,0,1,0,0,1,0,1 on 8 consecutive cycles with out_valid=1. Then out_valid=0, out_bit=0, busy=0.
- Send 8'hA5 then 8'h3C back-to-back, en=1 -> 16 consecutive valid bits 10100101 00111100 with no gap. in_ready=0 while hold is full; the third word is stalled until the reload edge.
- en pattern 1,0,1,0... with 8'hF0 -> 8 valid bits interleaved with invalid cycles (out_bit=0). Sequence 1111 0000 is intact; busy stays 1 until the last bit.
- MSB_FIRST=0, send 8'h01 -> first emitted bit 1, then seven 0s.
- Send 8'hFF, assert rst=0 after 3 bits mid-cycle -> out_valid/out_bit/busy drop to 0 without waiting for a clock edge, in_ready=1. After release, a new word 8'h80 emits 1 then seven 0s.
- With SERIALIZER_PARITY_EN, send 8'h07 then 8'h03 -> bits 00000111 1, then 00000011 0 (9 bits each, contiguous).
